// File: rtl/activation_if.sv
// activation_if: valid/ready input and output streams of the activation stage
interface activation_if #(
  parameter int LANES = 4,
  parameter int DW    = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [1:0]            in_mode;
  logic [DW-2:0]         in_max;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  modport slave (
    input  in_valid, in_data, in_mode, in_max, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_data, in_mode, in_max, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/activation_unit.sv
// activation_unit: two-stage per-lane bypass/ReLU/leaky/clamp activation with negative-lane counter
module activation_unit #(
  parameter int LANES      = 4,
  parameter int DW         = 32,
  parameter int LEAK_SHIFT = 3,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  activation_if.slave   bus,
  input  logic          stat_clr,
  output logic [CW-1:0] neg_count
);
  localparam int NW = $clog2(LANES + 1);
  localparam int SW = (CW > NW ? CW : NW) + 1;
  logic                s1_valid_q;
  logic [LANES*DW-1:0] s1_data_q;
  logic [1:0]          s1_mode_q;
  logic [DW-2:0]       s1_max_q;
  logic                s2_valid_q;
  logic [LANES*DW-1:0] s2_data_q;
  logic [LANES*DW-1:0] res_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [SW-1:0]       negs_d;
  logic [SW-1:0]       sum_d;
  logic                adv;
  logic                accept;
  // leaky shift kept in its own signed assignment so the arithmetic shift is not turned logical
  function automatic logic [DW-1:0] act(input logic signed [DW-1:0] x, input logic [1:0] m,
                                        input logic [DW-2:0] mx);
    logic signed [DW-1:0] lim;
    logic signed [DW-1:0] lk;
    lim = {1'b0, mx};
    lk  = x >>> LEAK_SHIFT;
    act = (m == 2'b00) ? x :
          x[DW-1]      ? ((m == 2'b10) ? lk : '0) :
          (m == 2'b11 && x > lim) ? lim : x;
  endfunction
  assign adv          = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid_q || adv);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign neg_count     = cnt_q;
  always_comb begin
    res_d  = '0;
    negs_d = '0;
    for (int i = 0; i < LANES; i++) begin
      res_d[i*DW +: DW] = act(s1_data_q[i*DW +: DW], s1_mode_q, s1_max_q);
      negs_d = negs_d + SW'(bus.in_data[i*DW + DW - 1]);
    end
    sum_d = SW'(cnt_q) + negs_d;
    cnt_d = (sum_d > SW'({CW{1'b1}})) ? '1 : sum_d[CW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_max_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= res_d;
      end
      if (!s1_valid_q || adv) s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_data_q <= bus.in_data;
        s1_mode_q <= bus.in_mode;
        s1_max_q  <= bus.in_max;
      end
      if (stat_clr) cnt_q <= '0;
      else if (accept && bus.in_mode != 2'b00) cnt_q <= cnt_d;
    end
  end
endmodule
